// File: rtl/ram_program_loader_if.sv
// Host word stream plus single-port RAM bus shared between the program loader
// (master) and the host/RAM side (slave).
interface ram_program_loader_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_cs;
  logic                  ram_we;
  logic                  ram_oe;

  modport master (
    input  in_valid, in_data, in_last, ram_rdata,
    output in_ready, ram_addr, ram_wdata, ram_cs, ram_we, ram_oe
  );

  modport slave (
    output in_valid, in_data, in_last, ram_rdata,
    input  in_ready, ram_addr, ram_wdata, ram_cs, ram_we, ram_oe
  );
endinterface

// File: rtl/ram_program_loader.sv
// Streams a program image into RAM from base_addr, then raises cpu_start.
// Define LOADER_VERIFY_EN to read back and compare every word (4 cycles/word).
module ram_program_loader #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  ram_program_loader_if.master  bus,
  output logic                  busy,
  output logic                  cpu_start,
  output logic [ADDR_WIDTH-1:0] pc_init,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow_err,
  output logic                  verify_err
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WR, S_RD, S_CMP, S_DONE} state_t;

  state_t                r_state, w_state_next;
  logic                  r_in_ready, w_in_ready_next;
  logic                  r_busy, w_busy_next;
  logic                  r_cpu_start, w_cpu_start_next;
  logic                  r_ram_cs, w_ram_cs_next;
  logic                  r_ram_we, w_ram_we_next;
  logic                  r_ram_oe, w_ram_oe_next;
  logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr_next;
  logic [DATA_WIDTH-1:0] r_ram_wdata, w_ram_wdata_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic [ADDR_WIDTH-1:0] r_pc_init, w_pc_init_next;
  logic [ADDR_WIDTH:0]   r_word_count, w_word_count_next;
  logic                  r_overflow, w_overflow_next;
`ifdef LOADER_VERIFY_EN
  logic                  r_end, w_end_next;
  logic                  r_verify_err, w_verify_err_next;
`endif

  logic w_start_ok, w_accept, w_at_top, w_end;
  assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_accept   = (r_state == S_LOAD) && r_in_ready && bus.in_valid;
  assign w_at_top   = &r_addr;
  assign w_end      = bus.in_last || w_at_top;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_cpu_start  <= 1'b0;
      r_ram_cs     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_oe     <= 1'b1;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_addr       <= '0;
      r_pc_init    <= '0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
`ifdef LOADER_VERIFY_EN
      r_end        <= 1'b0;
      r_verify_err <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_in_ready   <= w_in_ready_next;
      r_busy       <= w_busy_next;
      r_cpu_start  <= w_cpu_start_next;
      r_ram_cs     <= w_ram_cs_next;
      r_ram_we     <= w_ram_we_next;
      r_ram_oe     <= w_ram_oe_next;
      r_ram_addr   <= w_ram_addr_next;
      r_ram_wdata  <= w_ram_wdata_next;
      r_addr       <= w_addr_next;
      r_pc_init    <= w_pc_init_next;
      r_word_count <= w_word_count_next;
      r_overflow   <= w_overflow_next;
`ifdef LOADER_VERIFY_EN
      r_end        <= w_end_next;
      r_verify_err <= w_verify_err_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start_ok) w_state_next = S_LOAD;
`ifdef LOADER_VERIFY_EN
      S_LOAD: if (w_accept) w_state_next = S_WR;
      S_WR:   w_state_next = S_RD;
      S_RD:   w_state_next = S_CMP;
      S_CMP:  w_state_next = r_end ? S_DONE : S_LOAD;
`else
      S_LOAD: if (w_accept && w_end) w_state_next = S_WR;
      // Final word: one cycle with the strobe, one idle cycle, then DONE.
      S_WR:   if (!r_ram_we) w_state_next = S_DONE;
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready_next   = (w_state_next == S_LOAD);
    w_busy_next       = (w_state_next == S_LOAD) || (w_state_next == S_WR) ||
                        (w_state_next == S_RD)   || (w_state_next == S_CMP);
    w_cpu_start_next  = (w_state_next == S_DONE);
    w_ram_cs_next     = 1'b0;
    w_ram_we_next     = 1'b0;
    w_ram_oe_next     = 1'b1;
    w_ram_addr_next   = r_ram_addr;
    w_ram_wdata_next  = r_ram_wdata;
    w_addr_next       = r_addr;
    w_pc_init_next    = r_pc_init;
    w_word_count_next = r_word_count;
    w_overflow_next   = r_overflow;
`ifdef LOADER_VERIFY_EN
    w_end_next        = r_end;
    w_verify_err_next = r_verify_err;
`endif
    if (w_start_ok) begin
      w_pc_init_next    = base_addr;
      w_addr_next       = base_addr;
      w_word_count_next = '0;
      w_overflow_next   = 1'b0;
`ifdef LOADER_VERIFY_EN
      w_verify_err_next = 1'b0;
`endif
    end
    if (w_accept) begin
      w_ram_addr_next   = r_addr;
      w_ram_wdata_next  = bus.in_data;
      w_ram_cs_next     = 1'b1;
      w_ram_we_next     = 1'b1;
      w_ram_oe_next     = 1'b0;
      w_word_count_next = r_word_count + (ADDR_WIDTH+1)'(1);
      // The address saturates at the top; the load ends there anyway.
      if (!w_at_top) w_addr_next = r_addr + ADDR_WIDTH'(1);
      if (w_at_top && !bus.in_last) w_overflow_next = 1'b1;
`ifdef LOADER_VERIFY_EN
      w_end_next = w_end;
`endif
    end
`ifdef LOADER_VERIFY_EN
    if (r_state == S_WR) w_ram_cs_next = 1'b1;
    if (r_state == S_CMP && bus.ram_rdata != r_ram_wdata) w_verify_err_next = 1'b1;
`endif
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.ram_cs    = r_ram_cs;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_oe    = r_ram_oe;
  assign busy          = r_busy;
  assign cpu_start     = r_cpu_start;
  assign pc_init       = r_pc_init;
  assign word_count    = r_word_count;
  assign overflow_err  = r_overflow;
`ifdef LOADER_VERIFY_EN
  assign verify_err    = r_verify_err;
`else
  assign verify_err    = 1'b0;
`endif
endmodule

// File: doc/ram_program_loader.md
# ram_program_loader

Front-end stage that fills the CPU's single-port synchronous RAM with a program image and then releases the CPU. It accepts words from a host over a valid/ready stream and writes them to consecutive RAM addresses from a base address, using the RAM's `cs`/`we`/`oe` bus protocol. When the last word is written, it asserts a start level with the initial PC. It sits directly upstream of the fetch/execute sequencer and shares the RAM port with it; an external mux selects the loader while `busy` is high.

## Interface
Parameters:
- `ADDR_WIDTH`, 14, RAM address width.
- `DATA_WIDTH`, 16, RAM word width.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a load. Honoured only in IDLE or DONE.
- `base_addr`  in  ADDR_WIDTH  first load address, sampled with `start`.
- `in_valid`  in  1  host word valid.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  DATA_WIDTH  host word.
- `in_last`  in  1  marks the final word of the image.
- `ram_addr`  out  ADDR_WIDTH  RAM address (MAR).
- `ram_wdata`  out  DATA_WIDTH  write data; driven onto the RAM data bus when `ram_oe`=0.
- `ram_rdata`  in  DATA_WIDTH  RAM read data (bus when `ram_oe`=1).
- `ram_cs`  out  1  RAM chip select.
- `ram_we`  out  1  RAM write enable.
- `ram_oe`  out  1  RAM output enable; 0 means the loader drives the bus.
- `busy`  out  1  loader owns the RAM port.
- `cpu_start`  out  1  level; image loaded, CPU may run.
- `pc_init`  out  ADDR_WIDTH  latched `base_addr`, the CPU's initial PC.
- `word_count`  out  ADDR_WIDTH+1  words written in the current load.
- `overflow_err`  out  1  sticky; the image ran past the top address.
- `verify_err`  out  1  sticky; readback mismatch. Present only with verify built in; otherwise tied 0.

## Operation
- States: IDLE, LOAD, WR, RD, CMP, DONE.
- IDLE → LOAD on `start`. Also latches `pc_init`, loads the address counter with `base_addr`, and clears `word_count`, `overflow_err` and `verify_err`.
- In LOAD, `in_ready`=1. A word is accepted when `in_valid` and `in_ready` are both high at a rising edge.
- At the accept edge the loader registers `ram_addr`=addr, `ram_wdata`=`in_data`, `ram_cs`=1, `ram_we`=1, `ram_oe`=0. It then increments addr and `word_count`.
- Without verify, the FSM stays in LOAD and can accept one word per cycle. With verify, it goes LOAD → WR → RD → CMP → LOAD.
- If no word is accepted in a LOAD cycle, `ram_we`=0 and `ram_cs`=0 in the following cycle.
- An accepted `in_last` word ends the load: go to DONE after its write (or after its CMP).
- Accepting a word at addr = 2^ADDR_WIDTH−1 without `in_last` writes that word, sets `overflow_err`, and goes to DONE. The counter does not wrap.
- DONE: `busy`=0, `cpu_start`=1, `in_ready`=0, RAM outputs idle (`cs`=0, `we`=0, `oe`=1). `start` in DONE begins a new load and drops `cpu_start`.
- `start` while busy is ignored.
- `busy`=1 in LOAD, WR, RD and CMP.
- Reset, including mid-load: FSM → IDLE. All outputs take their reset values. A partially written image is abandoned.

## Timing
- Reset values: `in_ready`=0, `ram_addr`=0, `ram_wdata`=0, `ram_cs`=0, `ram_we`=0, `ram_oe`=1, `busy`=0, `cpu_start`=0, `pc_init`=0, `word_count`=0, `overflow_err`=0, `verify_err`=0.
- All outputs are registered; none has a combinational path from inputs.
- Accept at edge k → write strobe is visible during cycle k..k+1 → RAM commits at edge k+1.
- `cpu_start` rises on the edge after the last word's write cycle, i.e. 2 edges after the last accept without verify.
- Verify sequence:
  - WR: cycle k..k+1.
  - RD: `ram_we`=0, `ram_oe`=1, same address, cycle k+1..k+2.
  - RAM registers read data at edge k+2.
  - CMP: loader samples `ram_rdata` at edge k+3.
  - `in_ready` returns at edge k+3, giving 4 cycles per word.
- A mismatch sets `verify_err`, but loading continues.

## Configuration
- `LOADER_VERIFY_EN` defined: WR/RD/CMP readback path and a live `verify_err`.
- Undefined: no RD/CMP states, single-cycle throughput, `verify_err` constant 0.

## Test plan
- Stream 16 words ('h110C, 'h210E, …, 'hFFFF) from `base_addr`='h100 with `in_last` on the 16th → RAM 'h100–'h10F hold the image, `word_count`=16, `pc_init`='h100, `cpu_start`=1.
- Without verify, hold `in_valid`=1 continuously → one write per cycle, `in_ready` never drops before DONE. With verify → `in_ready` high exactly 1 of every 4 cycles.
- `base_addr`='h3FFE, send 3 words with no `in_last` → 'h3FFE and 'h3FFF written, `overflow_err`=1, third word never accepted, state DONE.
- Verify build, with a bench RAM model that forces `rdata`='hDEAD on address 'h105 → `verify_err`=1, all 16 words still written, `cpu_start`=1.
- Assert `rst_n`=0 after 5 words → all outputs reach reset values immediately. A new `start` with `base_addr`='h200 then loads correctly from 'h200.
- Toggle `in_valid` randomly and pulse `start` mid-load → no word lost or duplicated, `start` ignored.
